// File: rtl/mem_stage_pkg.sv
// Shared widths, load_op bit positions and bus layouts for the MEM stage.
// Optional forwarding payload is selected by MEM_FWD_EN in mem_stage.sv.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 40;

  // load_op one-hot bit positions
  localparam int LOP_B  = 0;
  localparam int LOP_BU = 1;
  localparam int LOP_H  = 2;
  localparam int LOP_HU = 3;
  localparam int LOP_W  = 4;

  typedef struct packed {
    logic [4:0]  load_op;
    logic        mem_req;
    logic        regw;
    logic [4:0]  waddr;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } ex_mem_t;

  typedef struct packed {
    logic        regw;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } mem_wb_t;

  typedef struct packed {
    logic        valid;
    logic        regw;
    logic [4:0]  waddr;
    logic [31:0] fwd;
    logic        load_wait;
  } mem_id_t;

endpackage

// File: rtl/mem_load_align.sv
// Byte/halfword selection and sign/zero extension of load data.
// Purely combinational; misalignment is EX's concern.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  i_load_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    unique case (1'b1)
      i_load_op[LOP_B]:  o_data = {{24{w_byte[7]}}, w_byte};
      i_load_op[LOP_BU]: o_data = {24'd0, w_byte};
      i_load_op[LOP_H]:  o_data = {{16{w_half[15]}}, w_half};
      i_load_op[LOP_HU]: o_data = {16'd0, w_half};
      default:           o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM response, aligns loads, feeds WB.
// MEM_FWD_EN: forward result data to ID instead of interlocking on all writes.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  output logic                    mem_allowin,
  input  logic                    ex_to_mem_valid,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic                    wb_allowin,
  output logic                    mem_to_wb_valid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata
);

  logic        r_valid;
  ex_mem_t     r_data;
  logic        r_rbuf_valid;
  logic [31:0] r_rbuf;

  logic        w_ready_go;
  logic        w_rsp_take;
  logic        w_is_load;
  logic [31:0] w_rdata;
  logic [31:0] w_aligned;
  logic [31:0] w_wdata;
  mem_wb_t     w_wb;
  mem_id_t     w_id;

  assign w_ready_go = ~r_data.mem_req | data_sram_data_ok | r_rbuf_valid;
  assign mem_allowin = ~r_valid | (w_ready_go & wb_allowin);
  assign mem_to_wb_valid = r_valid & w_ready_go;

  assign w_rsp_take = r_valid & r_data.mem_req & ~r_rbuf_valid
                    & data_sram_data_ok;
  assign w_rdata = r_rbuf_valid ? r_rbuf : data_sram_rdata;
  assign w_is_load = |r_data.load_op;

  mem_load_align u_align (
    .i_load_op (r_data.load_op),
    .i_addr    (r_data.alu_result[1:0]),
    .i_rdata   (w_rdata),
    .o_data    (w_aligned)
  );

  assign w_wdata = w_is_load ? w_aligned : r_data.alu_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_rbuf_valid <= 1'b0;
      r_rbuf       <= 32'd0;
    end else begin
      if (mem_allowin)
        r_valid <= ex_to_mem_valid;
      if (mem_allowin & ex_to_mem_valid)
        r_data <= ex_to_mem_bus;
      // hold the response while WB is blocked
      if (mem_to_wb_valid & wb_allowin) begin
        r_rbuf_valid <= 1'b0;
      end else if (w_rsp_take & ~wb_allowin) begin
        r_rbuf_valid <= 1'b1;
        r_rbuf       <= data_sram_rdata;
      end
    end
  end

  always_comb begin
    w_wb.regw  = r_data.regw;
    w_wb.waddr = r_data.waddr;
    w_wb.wdata = w_wdata;
    w_wb.pc    = r_data.pc;
    w_id.valid = r_valid;
    w_id.regw  = r_data.regw;
    w_id.waddr = r_data.waddr;
`ifdef MEM_FWD_EN
    w_id.fwd       = w_wdata;
    w_id.load_wait = r_valid & w_is_load & ~w_ready_go;
`else
    w_id.fwd       = 32'd0;
    w_id.load_wait = r_valid & r_data.regw;
`endif
  end

  assign mem_to_wb_bus = w_wb;
  assign mem_to_id_bus = w_id;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Expectations follow the MEM_FWD_EN setting of the build.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        mem_allowin;
  logic        ex_to_mem_valid;
  logic [75:0] ex_to_mem_bus;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [39:0] mem_to_id_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .mem_allowin       (mem_allowin),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .ex_to_mem_bus     (ex_to_mem_bus),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .mem_to_id_bus     (mem_to_id_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [75:0] mk(
    input logic [4:0] lop, input logic req, input logic regw,
    input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] pc);
    return {lop, req, regw, wa, alu, pc};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mem_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_allowin got=%b exp=1", mem_allowin);
    end
    checks++;
    if (mem_to_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb_valid got=%b exp=0", mem_to_wb_valid);
    end
    checks++;
    if (mem_to_id_bus !== 40'd0) begin
      errors++;
      $display("FAIL reset_id_bus got=%h exp=0", mem_to_id_bus);
    end
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] lop, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp,
                         input string nm);
    @(negedge clk);
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(lop, 1'b1, 1'b1, 5'd7, addr, 32'h1c00_0100);
    wb_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = rd;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[63:32] !== exp) begin
      errors++;
      $display("FAIL %s got v=%b d=%h exp v=1 d=%h", nm,
               mem_to_wb_valid, mem_to_wb_bus[63:32], exp);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_load_align();
    do_load(5'b00001, 32'h1003, 32'h80FF_0000, 32'hFFFF_FF80, "ld_b");
    do_load(5'b00010, 32'h1003, 32'h80FF_0000, 32'h0000_0080, "ld_bu");
    do_load(5'b00100, 32'h1002, 32'h8001_1234, 32'hFFFF_8001, "ld_h");
    do_load(5'b01000, 32'h1002, 32'h8001_1234, 32'h0000_8001, "ld_hu");
    do_load(5'b00010, 32'h1002, 32'h80FF_0000, 32'h0000_00FF, "ld_bu_a2");
    do_load(5'b00100, 32'h1000, 32'h8001_F234, 32'hFFFF_F234, "ld_h_a0");
    do_load(5'b10000, 32'h1000, 32'hCAFE_F00D, 32'hCAFE_F00D, "ld_w");
  endtask

  task automatic test_load_wait();
    @(negedge clk);
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(5'b10000, 1'b1, 1'b1, 5'd9, 32'h2000, 32'h1c00_0200);
    wb_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h5555_AAAA;
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b0 ||
          mem_to_id_bus[0] !== 1'b1) begin
        errors++;
        $display("FAIL wait_c%0d got v=%b al=%b lw=%b exp 0 0 1", i,
                 mem_to_wb_valid, mem_allowin, mem_to_id_bus[0]);
      end
      @(negedge clk);
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b1 || mem_allowin !== 1'b1 ||
        mem_to_wb_bus[63:32] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wait_c3 got v=%b al=%b d=%h exp 1 1 12345678",
               mem_to_wb_valid, mem_allowin, mem_to_wb_bus[63:32]);
    end
    checks++;
`ifdef MEM_FWD_EN
    if (mem_to_id_bus[0] !== 1'b0 || mem_to_id_bus[32:1] !== 32'h1234_5678) begin
`else
    if (mem_to_id_bus[0] !== 1'b1 || mem_to_id_bus[32:1] !== 32'd0) begin
`endif
      errors++;
      $display("FAIL wait_c3_id got lw=%b fwd=%h", mem_to_id_bus[0],
               mem_to_id_bus[32:1]);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_rbuf();
    @(negedge clk);
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(5'b10000, 1'b1, 1'b1, 5'd3, 32'h3000, 32'h1c00_0300);
    wb_allowin = 1'b1;
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    wb_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0000_0000;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[63:32] !== 32'hDEAD_BEEF ||
        mem_allowin !== 1'b0) begin
      errors++;
      $display("FAIL rbuf_hold got v=%b d=%h al=%b exp 1 deadbeef 0",
               mem_to_wb_valid, mem_to_wb_bus[63:32], mem_allowin);
    end
    @(negedge clk);
    wb_allowin = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b1 || mem_to_wb_bus[63:32] !== 32'hDEAD_BEEF ||
        mem_allowin !== 1'b1) begin
      errors++;
      $display("FAIL rbuf_release got v=%b d=%h al=%b exp 1 deadbeef 1",
               mem_to_wb_valid, mem_to_wb_bus[63:32], mem_allowin);
    end
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(5'b10000, 1'b1, 1'b1, 5'd4, 32'h3004, 32'h1c00_0304);
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b0) begin
      errors++;
      $display("FAIL rbuf_cleared got v=%b al=%b exp 0 0",
               mem_to_wb_valid, mem_allowin);
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_add_store();
    @(negedge clk);
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(5'b00000, 1'b0, 1'b1, 5'd4, 32'h5, 32'h1c00_0400);
    wb_allowin = 1'b1;
    @(negedge clk);
    ex_to_mem_bus = mk(5'b00000, 1'b1, 1'b0, 5'd0, 32'h4000, 32'h1c00_0404);
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b1 || mem_allowin !== 1'b1 ||
        mem_to_wb_bus[69:32] !== {1'b1, 5'd4, 32'h5}) begin
      errors++;
      $display("FAIL add_pass got v=%b al=%b bus=%h", mem_to_wb_valid,
               mem_allowin, mem_to_wb_bus);
    end
    checks++;
`ifdef MEM_FWD_EN
    if (mem_to_id_bus !== {1'b1, 1'b1, 5'd4, 32'h5, 1'b0}) begin
`else
    if (mem_to_id_bus !== {1'b1, 1'b1, 5'd4, 32'h0, 1'b1}) begin
`endif
      errors++;
      $display("FAIL add_id got=%h", mem_to_id_bus);
    end
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b0) begin
      errors++;
      $display("FAIL store_stall got v=%b al=%b exp 0 0",
               mem_to_wb_valid, mem_allowin);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b1 ||
        mem_to_wb_bus[69:32] !== {1'b0, 5'd0, 32'h4000}) begin
      errors++;
      $display("FAIL store_done got v=%b bus=%h", mem_to_wb_valid,
               mem_to_wb_bus);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [3];
    rd[0] = 32'hA0A0_0001;
    rd[1] = 32'hB0B0_0002;
    rd[2] = 32'hC0C0_0003;
    @(negedge clk);
    wb_allowin = 1'b1;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(5'b10000, 1'b1, 1'b1, 5'd10, 32'h5000, 32'h1c00_0500);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_to_mem_valid = (i < 2);
      ex_to_mem_bus = mk(5'b10000, 1'b1, 1'b1, 5'(11 + i), 32'h5004 + 4 * i,
                         32'h1c00_0504 + 4 * i);
      data_sram_data_ok = 1'b1;
      data_sram_rdata = rd[i];
      #1;
      checks++;
      if (mem_to_wb_valid !== 1'b1 || mem_allowin !== 1'b1 ||
          mem_to_wb_bus[68:32] !== {5'(10 + i), rd[i]}) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b al=%b bus=%h", i, mem_to_wb_valid,
                 mem_allowin, mem_to_wb_bus);
      end
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    ex_to_mem_valid = 1'b0;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain got v=%b al=%b exp 0 1",
               mem_to_wb_valid, mem_allowin);
    end
  endtask

  task automatic test_stray_ok();
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h7777_7777;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(5'b10000, 1'b1, 1'b1, 5'd5, 32'h6000, 32'h1c00_0600);
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_ok got v=%b exp 0", mem_to_wb_valid);
    end
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wb_allowin = 1'b1;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(5'b00001, 1'b1, 1'b1, 5'd6, 32'h7001, 32'h1c00_0700);
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    #1;
    checks++;
    if (mem_to_id_bus[39] !== 1'b1 || mem_to_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre got mv=%b v=%b exp 1 0",
               mem_to_id_bus[39], mem_to_wb_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b1 ||
        mem_to_id_bus !== 40'd0) begin
      errors++;
      $display("FAIL rstmid_now got v=%b al=%b id=%h exp 0 1 0",
               mem_to_wb_valid, mem_allowin, mem_to_id_bus);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h9999_9999;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stray got v=%b exp 0", mem_to_wb_valid);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk(5'b10000, 1'b1, 1'b1, 5'd8, 32'h7100, 32'h1c00_0710);
    @(negedge clk);
    ex_to_mem_valid = 1'b0;
    #1;
    checks++;
    if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after got v=%b al=%b exp 0 0",
               mem_to_wb_valid, mem_allowin);
    end
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ex_to_mem_valid = 1'b0;
    ex_to_mem_bus = '0;
    wb_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'd0;
    test_reset();
    test_load_align();
    test_load_wait();
    test_rbuf();
    test_add_store();
    test_back_to_back();
    test_stray_ok();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
